// File: rtl/rr_binenc_pkg.sv
// Shared types for the rr_binenc arbiter encoder.
`ifndef DEFAULT_WIDTH
`define DEFAULT_WIDTH 8
`endif

package rr_binenc_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/prienc_mask.sv
// Masked priority encoder: lowest set bit at or above start_i, else lowest set bit overall.
module prienc_mask #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  output logic         found_o,
  output logic [W-1:0] idx_o,
  output logic [N-1:0] onehot_o
);

  logic         hi_found_c;
  logic [W-1:0] hi_idx_c;
  logic         lo_found_c;
  logic [W-1:0] lo_idx_c;

  // Two passes in one loop; scanning downward leaves the lowest match in each pass.
  always_comb begin
    hi_found_c = 1'b0;
    hi_idx_c   = '0;
    lo_found_c = 1'b0;
    lo_idx_c   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_found_c = 1'b1;
        lo_idx_c   = W'(i);
        if (i >= int'(start_i)) begin
          hi_found_c = 1'b1;
          hi_idx_c   = W'(i);
        end
      end
    end
  end

  assign found_o  = lo_found_c;
  assign idx_o    = hi_found_c ? hi_idx_c : lo_idx_c;
  assign onehot_o = lo_found_c ? (N'(1) << idx_o) : '0;

endmodule

// File: rtl/rr_binenc.sv
// Registered valid/ready binary encoder with fixed-priority or round-robin selection.
module rr_binenc
  import rr_binenc_pkg::*;
#(
  parameter  int unsigned N           = `DEFAULT_WIDTH,
  parameter  int unsigned ROUND_ROBIN = 1,
  localparam int unsigned W           = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] out_onehot
);

  state_e       state_q, state_d;
  logic [W-1:0] idx_q, idx_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic [W-1:0] start_c;
  logic         win_found_c;
  logic [W-1:0] win_idx_c;
  logic [N-1:0] win_onehot_c;
  logic         accept_c;
  logic         select_c;

  assign accept_c = (state_q == ST_HOLD) && out_ready;
  assign select_c = (state_q == ST_IDLE) || out_ready;

  // Pointer moves one past the accepted winner; the same-cycle selection already sees it.
  always_comb begin
    ptr_d = ptr_q;
    if ((ROUND_ROBIN != 0) && accept_c) begin
      ptr_d = (idx_q == W'(N - 1)) ? '0 : idx_q + W'(1);
    end
  end

  generate
    if (ROUND_ROBIN != 0) begin : g_rr
      assign start_c = ptr_d;
    end else begin : g_fixed
      assign start_c = '0;
    end
  endgenerate

  prienc_mask #(
    .N (N)
  ) u_enc (
    .req_i    (req),
    .start_i  (start_c),
    .found_o  (win_found_c),
    .idx_o    (win_idx_c),
    .onehot_o (win_onehot_c)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    if (select_c) begin
      if (win_found_c) begin
        state_d  = ST_HOLD;
        idx_d    = win_idx_c;
        onehot_d = win_onehot_c;
      end else begin
        state_d  = ST_IDLE;
        onehot_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      ptr_q    <= ptr_d;
    end
  end

  assign out_valid  = (state_q == ST_HOLD);
  assign out_idx    = idx_q;
  assign out_onehot = onehot_q;

endmodule
